fifo1_sync: RTL and testbench
=============================

// Module: fifo1_sync
// PURPOSE
//   Single-clock FIFO with show-ahead read data and registered full/empty flags.
//   Buffers byte-wide data between a producer (winc/wdata) and a consumer (rinc/rdata) in one clock domain.
//   Binary read/write pointers carry one extra wrap bit; the storage is a dual-port array.
// PARAMETERS
//   DSIZE  8  data width in bits
//   ASIZE  4  address width; depth = 2**ASIZE = 16 entries
// PORTS
//   clk     in   1          single clock; all logic is rising-edge
//   rst_n   in   1          reset, synchronous and active-low
//   winc    in   1          write request; accepted only when wfull==0
//   wdata   in   DSIZE      write data, captured on an accepted write
//   wfull   out  1          FIFO holds 2**ASIZE entries
//   rinc    in   1          read request (pop); accepted only when rempty==0
//   rdata   out  DSIZE      data at the head of the FIFO (show-ahead)
//   rempty  out  1          FIFO holds 0 entries
//   wlevel  out  ASIZE+1    occupancy 0..2**ASIZE; present only with FIFO1_SYNC_LEVEL_EN
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low.
//   - Reset (rst_n==0 at clk edge): wptr=rptr=0, rempty=1, wfull=0, wlevel=0.
//     Memory is not reset. Reset asserted mid-operation discards all contents at that edge.
//   - Write: on an edge with winc && !wfull, mem[wptr[ASIZE-1:0]]<=wdata and wptr<=wptr+1.
//     winc while wfull==1 is ignored; no change to pointers or memory.
//   - Read: on an edge with rinc && !rempty, rptr<=rptr+1.
//     rinc while rempty==1 is ignored.
//   - rdata = mem[rptr[ASIZE-1:0]], a combinational read.
//     It is the head entry whenever rempty==0 and is don't-care while rempty==1.
//   - Pointers are ASIZE+1 bits and wrap naturally modulo 2**(ASIZE+1).
//   - Flags are registered and computed from the next-state pointers:
//     rempty_n = (rptr_n == wptr_n)
//     wfull_n  = (wptr_n[ASIZE] != rptr_n[ASIZE]) && (wptr_n[ASIZE-1:0] == rptr_n[ASIZE-1:0])
//   - Latency:
//     - A write accepted at edge k into an empty FIFO clears rempty after edge k.
//     - rdata shows that word in the same cycle.
//     - The 16th un-read write sets wfull after its edge.
//   - Simultaneous winc and rinc:
//     - Neither flag set: both happen and occupancy is unchanged.
//     - While full: only the read happens (write blocked); wfull clears next cycle.
//     - While empty: only the write happens; rempty clears next cycle.
//   - Order is strictly first-in first-out; there is no data loss or duplication across pointer wrap.
// CONFIGURATION
//   FIFO1_SYNC_LEVEL_EN
//     defined: adds output wlevel = wptr - rptr, modulo 2**(ASIZE+1), registered with the pointers.
//       Reset value is 0; range is 0..16.
//     undefined: the wlevel port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//   - Package fifo1_sync_pkg: default DSIZE/ASIZE constants and the depth constant DEPTH = 1<<ASIZE.
//   - Sub-module fifo1_sync_mem: DEPTH x DSIZE array, synchronous write (wclken, waddr, wdata),
//     asynchronous read (raddr -> rdata).
//   - Top level holds pointers, flag registers and the optional level register.
// TESTING
//   1 Reset: hold rst_n=0 for 3 edges -> rempty=1, wfull=0, wlevel=0.
//     Pulse winc during reset -> FIFO still empty after release.
//   2 Fill: 20 consecutive winc with values 0x01..0x14 ->
//     wfull=1 after the 16th accepted write; writes 17..20 are ignored; wlevel=16.
//   3 Drain: rinc held for 20 cycles ->
//     rdata sequence 0x01..0x10, rempty=1 after the 16th pop; further rinc ignored; wlevel=0.
//   4 Show-ahead: a single write of 0xA5 into an empty FIFO ->
//     next cycle rempty=0 and rdata=0xA5 with no rinc needed.
//   5 Streaming: winc=rinc=1 for 100 cycles with one word preloaded ->
//     every word comes out in order across several pointer wraps; occupancy stays 1; no flag toggles.
//   6 Full + read: full FIFO with winc=rinc=1 for one edge ->
//     only the pop occurs, wfull=0 next cycle, wlevel=15.

Source files
------------

// File: rtl/fifo1_sync_pkg.sv
// fifo1_sync_pkg: default geometry for the single-clock show-ahead FIFO
package fifo1_sync_pkg;
  localparam int DEF_DSIZE = 8;
  localparam int DEF_ASIZE = 4;
  localparam int DEPTH = 1 << DEF_ASIZE;
  function automatic int depth_of(input int asize);
    return 1 << asize;
  endfunction
endpackage

// File: rtl/fifo1_sync_if.sv
// fifo1_sync_if: producer/consumer handshake bundle; wlevel exists only with FIFO1_SYNC_LEVEL_EN
interface fifo1_sync_if
  import fifo1_sync_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
);
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
`ifdef FIFO1_SYNC_LEVEL_EN
  logic [ASIZE:0]   wlevel;
  modport master (output winc, wdata, rinc, input wfull, rdata, rempty, wlevel);
  modport slave  (input winc, wdata, rinc, output wfull, rdata, rempty, wlevel);
`else
  modport master (output winc, wdata, rinc, input wfull, rdata, rempty);
  modport slave  (input winc, wdata, rinc, output wfull, rdata, rempty);
`endif
endinterface

// File: rtl/fifo1_sync_mem.sv
// fifo1_sync_mem: DEPTH x DSIZE storage, synchronous write, asynchronous read
module fifo1_sync_mem
  import fifo1_sync_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
) (
  input  logic             clk,
  input  logic             wclken,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);
  logic [DSIZE-1:0] mem_q [depth_of(ASIZE)];
  always_ff @(posedge clk)
    if (wclken) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fifo1_sync.sv
// fifo1_sync: single-clock FIFO with show-ahead read and registered flags.
// Define FIFO1_SYNC_LEVEL_EN to add the registered wlevel occupancy output.
module fifo1_sync
  import fifo1_sync_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
) (
  input  logic         clk,
  input  logic         rst_n,
  fifo1_sync_if.slave  bus
);
  logic [ASIZE:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic           wfull_q, wfull_d, rempty_q, rempty_d;
  logic           w_en, r_en;
  assign w_en = bus.winc && !wfull_q;
  assign r_en = bus.rinc && !rempty_q;
  always_comb begin
    wptr_d   = wptr_q + (ASIZE+1)'(w_en);
    rptr_d   = rptr_q + (ASIZE+1)'(r_en);
    rempty_d = rptr_d == wptr_d;
    wfull_d  = (wptr_d[ASIZE] != rptr_d[ASIZE]) && (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
    end
`ifdef FIFO1_SYNC_LEVEL_EN
  logic [ASIZE:0] wlevel_q;
  always_ff @(posedge clk)
    if (!rst_n) wlevel_q <= '0;
    else wlevel_q <= wptr_d - rptr_d;
  assign bus.wlevel = wlevel_q;
`endif
  assign bus.wfull  = wfull_q;
  assign bus.rempty = rempty_q;
  fifo1_sync_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .clk   (clk),
    .wclken(w_en),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (bus.wdata),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (bus.rdata)
  );
endmodule

// File: tb/tb_fifo1_sync.sv
// tb_fifo1_sync: randomized bench against a queue model of the FIFO
module tb_fifo1_sync;
  logic clk = 1'b0;
  logic rst_n;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] q[$];
  fifo1_sync_if #(.DSIZE(8), .ASIZE(4)) bus ();
  fifo1_sync #(.DSIZE(8), .ASIZE(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_state();
    chk("rempty", 32'(bus.rempty), 32'(q.size() == 0));
    chk("wfull", 32'(bus.wfull), 32'(q.size() == 16));
    if (q.size() > 0) chk("rdata", 32'(bus.rdata), 32'(q[0]));
`ifdef FIFO1_SYNC_LEVEL_EN
    chk("wlevel", 32'(bus.wlevel), 32'(q.size()));
`endif
  endtask
  // Drive inputs, let the model react at the edge, then compare on the falling edge
  task automatic tick(input bit w, input logic [7:0] d, input bit r);
    bit was_full, was_empty;
    bus.winc = w;
    bus.wdata = d;
    bus.rinc = r;
    @(posedge clk);
    was_full = q.size() == 16;
    was_empty = q.size() == 0;
    if (!rst_n) q.delete();
    else begin
      if (r && !was_empty) void'(q.pop_front());
      if (w && !was_full) q.push_back(d);
    end
    @(negedge clk);
    check_state();
  endtask
  initial begin
    rst_n = 1'b0;
    bus.winc = 1'b0;
    bus.wdata = '0;
    bus.rinc = 1'b0;
    tick(0, 8'h00, 0);
    tick(1, 8'h77, 0);
    tick(0, 8'h00, 0);
    rst_n = 1'b1;
    tick(0, 8'h00, 0);
    chk("reset_empty", 32'(bus.rempty), 32'd1);
    for (int i = 1; i <= 20; i++) tick(1, 8'(i), 0);
    chk("fill_full", 32'(bus.wfull), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      if (i <= 16) chk("drain_seq", 32'(bus.rdata), 32'(i));
      tick(0, 8'h00, 1);
    end
    chk("drain_empty", 32'(bus.rempty), 32'd1);
    tick(1, 8'hA5, 0);
    chk("show_ahead", 32'(bus.rdata), 32'hA5);
    for (int i = 0; i < 100; i++) begin
      tick(1, 8'($urandom), 1);
      chk("stream_occ", 32'(q.size()), 32'd1);
    end
    tick(0, 8'h00, 1);
    for (int i = 0; i < 16; i++) tick(1, 8'($urandom), 0);
    tick(1, 8'h5A, 1);
    chk("full_read_wfull", 32'(bus.wfull), 32'd0);
    chk("full_read_occ", 32'(q.size()), 32'd15);
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      tick(bit'($urandom_range(0, 99) < 55), 8'($urandom), bit'($urandom_range(0, 99) < 45));
      rst_n = 1'b1;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
